// File: rtl/n64_controller_responder.sv
// N64 controller responder: decodes the console's 8-bit command on the
// open-drain data line and answers with the identity word or button status.
module n64_controller_responder #(
  parameter int unsigned BIT_CYCLES = 200,
  parameter int unsigned SHORT_LOW  = 50,
  parameter int unsigned LONG_LOW   = 150,
  parameter int unsigned SAMPLE_AT  = 100,
  parameter int unsigned REPLY_GAP  = 100,
  parameter int unsigned RX_TIMEOUT = 400
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        n64d_in,
  output logic        n64d_oe,
  input  logic [31:0] button_data,
  input  logic [23:0] identity,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BIT_C    = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] SHORT_C  = CW'(SHORT_LOW);
  localparam logic [CW-1:0] LONG_C   = CW'(LONG_LOW);
  localparam logic [CW-1:0] SAMPLE_C = CW'(SAMPLE_AT);
  localparam logic [CW-1:0] GAP_C    = CW'(REPLY_GAP);
  localparam logic [CW-1:0] STOP_C   = CW'(2 * SHORT_LOW);
  // Counter starts one cycle after the edge, so aborting at this count lands
  // the return to IDLE exactly RX_TIMEOUT cycles after the synchronized edge.
  localparam logic [CW-1:0] TMO_C    = CW'(RX_TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE,
    RX_BIT,
    RX_STOP,
    GAP,
    TX_BIT,
    TX_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bits_q, bits_d;
  logic [7:0]    rx_q, rx_d;
  logic [31:0]   tx_q, tx_d;
  logic          phase_q, phase_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          busy_q, busy_d;
  logic          oe_q, oe_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          fall, rise;

  // Two-flop synchronizer plus previous-cycle copy for edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= n64d_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;
  assign rise = ~prev_q & sync2_q;

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      phase_q     <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      phase_q     <= phase_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      oe_q        <= oe_d;
    end
  end

  // Next-state logic; line drive is derived from the next state so that the
  // registered output tracks the state/counter pair exactly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bits_d      = bits_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    phase_d     = phase_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    busy_d      = busy_q;
    oe_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = RX_BIT;
          busy_d  = 1'b1;
          bits_d  = '0;
          phase_d = 1'b0;
        end
      end

      RX_BIT: begin
        if (cnt_q == SAMPLE_C) begin
          rx_d   = {rx_q[6:0], sync2_q};
          bits_d = bits_q + 6'd1;
          if (bits_q == 6'd7) begin
            state_d = RX_STOP;
            cnt_d   = '0;
            phase_d = 1'b0;
          end
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q >= TMO_C) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      RX_STOP: begin
        if (!phase_q) begin
          if (fall) begin
            phase_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q >= TMO_C) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else if (rise) begin
          cmd_byte_d  = rx_q;
          cmd_valid_d = 1'b1;
          cnt_d       = '0;
          if (rx_q == 8'h00 || rx_q == 8'hFF) begin
            tx_d    = {identity, 8'h00};
            bits_d  = 6'd24;
            state_d = GAP;
          end else if (rx_q == 8'h01) begin
            tx_d    = button_data;
            bits_d  = 6'd32;
            state_d = GAP;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else if (cnt_q >= TMO_C) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      GAP: begin
        if (cnt_q == GAP_C - 1'b1) begin
          state_d = TX_BIT;
          cnt_d   = '0;
        end
      end

      TX_BIT: begin
        if (cnt_q == BIT_C - 1'b1) begin
          cnt_d  = '0;
          tx_d   = {tx_q[30:0], 1'b0};
          bits_d = bits_q - 6'd1;
          if (bits_q == 6'd1) begin
            state_d = TX_STOP;
          end
        end
      end

      TX_STOP: begin
        if (cnt_q == STOP_C - 1'b1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    if (state_d == TX_BIT) begin
      oe_d = (cnt_d < (tx_d[31] ? SHORT_C : LONG_C));
    end else if (state_d == TX_STOP) begin
      oe_d = (cnt_d < STOP_C);
    end
  end

  assign n64d_oe   = oe_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign busy      = busy_q;

endmodule

// File: doc/n64_controller_responder.md
Name: n64_controller_responder

Overview:
- Device-side end of the N64 single-wire controller protocol. It makes the FPGA look like a standard N64 controller to a console or to our own polling host.
- Decodes the 8-bit command the console sends on the shared open-drain data line.
- Answers with the identity reply (commands 0x00/0xFF) or the 32-bit button status (command 0x01) from an input word.
- Sits beside the top-level tristate pad. The top drives the pad low when n64d_oe=1, otherwise leaves it high-Z.

Parameters:
BIT_CYCLES, 200, sys_clk cycles per protocol bit (4 us at 50 MHz)
SHORT_LOW, 50, low time for a '1' bit and half the stop bit (1 us)
LONG_LOW, 150, low time for a '0' bit (3 us)
SAMPLE_AT, 100, cycles after a falling edge at which an RX bit is sampled (2 us)
REPLY_GAP, 100, cycles from the console stop-bit rising edge to the first TX falling edge
RX_TIMEOUT, 400, max cycles without a falling edge mid-command before abort

Ports:
sys_clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
n64d_in  in  1  raw pad input (asynchronous to sys_clk)
n64d_oe  out  1  1 = pull line low, 0 = release (high-Z)
button_data  in  32  status word sent MSB first for command 0x01
identity  in  24  identity reply, expected 24'h050002
cmd_valid  out  1  one-cycle pulse when a complete command + stop bit is decoded
cmd_byte  out  8  last decoded command, valid from cmd_valid onward
busy  out  1  high from the first command falling edge until TX stop bit complete

Behaviour:
- Reset values (async on rst_n low, takes effect with no clock): n64d_oe=0, cmd_valid=0, cmd_byte=8'h00, busy=0, state=IDLE, all counters 0. Reset mid-transmit releases the line immediately.
- n64d_in passes through a 2-FF synchronizer. Edge detection uses the synchronized value and its previous-cycle copy.
- IDLE: wait for a falling edge, then set busy=1, clear bit count and cycle counter, and go to RX_BIT.
- RX_BIT:
  - Counter runs from the falling edge. At count SAMPLE_AT, shift the synced level in MSB first (high=1, low=0).
  - After bit 8 is shifted, go to RX_STOP. Otherwise wait for the next falling edge, restart the counter, and take the next bit.
  - If no falling edge arrives within RX_TIMEOUT cycles, go to IDLE with busy=0 and no cmd_valid.
- RX_STOP:
  - Require a falling edge, then a rising edge. Each edge must arrive within RX_TIMEOUT, else abort to IDLE.
  - On the rising edge: latch cmd_byte and pulse cmd_valid for one cycle.
  - If the command is 0x00, 0xFF or 0x01, load the shift register in that same cycle, then go to GAP. For 0x00/0xFF load identity, length 24. For 0x01 load a button_data snapshot, length 32.
  - Otherwise go to IDLE with busy=0.
- GAP: count REPLY_GAP cycles with n64d_oe=0, then go to TX_BIT.
- TX_BIT:
  - Each bit takes exactly BIT_CYCLES cycles. n64d_oe=1 for the first SHORT_LOW cycles ('1') or LONG_LOW cycles ('0'), then 0.
  - Bits go MSB first, back to back. After the last bit, go to TX_STOP.
- TX_STOP: n64d_oe=1 for 2*SHORT_LOW cycles, then 0. Go to IDLE and drop busy in the same cycle.
- The line input is ignored during GAP, TX_BIT and TX_STOP.
- Changes to button_data after the snapshot cycle do not affect the reply in progress.
- A falling edge that arrives on the same cycle IDLE is entered from TX_STOP is not taken. The next falling edge starts a command.
- Response latency: the first TX falling edge comes REPLY_GAP+1 cycles after the stop-bit rising edge is seen on the synchronized input.

Test Plan:
- Drive command 0x01 with a 2 us-low stop bit and button_data=32'h8000_00FF. Required: one cmd_valid pulse, cmd_byte=0x01, and after the gap 32 TX bits. Bit 0 is 50 cycles low, bits 1-23 are 150 low, bits 24-31 are 50 low, then 100 low for stop. busy drops at the end.
- Command 0x00, then 0xFF, with identity=24'h050002. Required: a 24-bit reply decoding to 0x050002 each time, followed by the 100-cycle stop low.
- Command 0x5A. Required: cmd_valid pulse with cmd_byte=0x5A, n64d_oe stays 0, busy=0 one cycle after the stop rising edge.
- Send 4 command bits, then hold the line high. Required: abort 400 cycles after the last falling edge, busy=0, no cmd_valid, and a following complete 0x01 command is answered normally.
- During a 0x01 reply, change button_data from 32'hFFFF_FFFF to 0 at bit 10. Required: all 32 bits are sent as '1'.
- Assert rst_n low mid-TX while n64d_oe=1. Required: n64d_oe=0 and busy=0 before the next sys_clk edge. After release, the block is in IDLE and responds to a new command.
